regfile: RTL and testbench
==========================

// Module: regfile
// PURPOSE
//   MIPS general-purpose register file: the consumer end of the writeback port (reg_d_*).
//   Provides two read ports (rs/s, rt/t) to the decode stage and one write port from writeback.
//   r0 is hardwired to zero. Writes bypass to same-cycle reads.
//   After reset, a sequencer clears every register to zero and holds init_busy so the pipeline stalls.
// PARAMETERS
//   ADDR_SIZE  5   register address width; depth = 2**ADDR_SIZE
//   WORD_SIZE  32  register data width
// PORTS
//   clk         in   1          rising-edge clock, single clock domain
//   rst         in   1          synchronous, active-high reset
//   reg_d_we    in   1          write enable from writeback
//   reg_d_addr  in   ADDR_SIZE  write address
//   reg_d_data  in   WORD_SIZE  write data
//   reg_s_addr  in   ADDR_SIZE  read port s address (rs)
//   reg_s_data  out  WORD_SIZE  read port s data, combinational
//   reg_t_addr  in   ADDR_SIZE  read port t address (rt)
//   reg_t_data  out  WORD_SIZE  read port t data, combinational
//   init_busy   out  1          high while clear sequence runs; pipeline must stall
// BEHAVIOUR
//   Clocking and reset
//   - One clock, clk. Reset is synchronous and active-high on rst.
//   - rst=1 at an edge: state<=CLEAR, clr_cnt<=1, init_busy<=1 (registered).
//   - Reset value of init_busy is 1.
//   Clear FSM (states CLEAR, READY)
//   - CLEAR: each edge writes mem[clr_cnt]<=0, then clr_cnt<=clr_cnt+1.
//   - When clr_cnt==2**ADDR_SIZE-1: state<=READY, init_busy<=0.
//   - init_busy is high for exactly 2**ADDR_SIZE-1 edges after the rst edge (31 by default).
//   - rst asserted mid-CLEAR or in READY restarts the sequence at clr_cnt=1. No other transitions.
//   - clr_cnt is ADDR_SIZE bits wide. It never wraps; the FSM leaves CLEAR at the maximum value.
//   Write port
//   - In READY, when reg_d_we=1 and reg_d_addr!=0: mem[reg_d_addr]<=reg_d_data at the edge.
//   - Writes to address 0 are discarded.
//   - Writes arriving while state==CLEAR (including the rst cycle) are discarded.
//   Read ports (identical; x in {s,t})
//   - reg_x_addr==0 gives 0.
//   - Otherwise, state==CLEAR gives 0.
//   - Otherwise, reg_d_we && reg_d_addr==reg_x_addr gives reg_d_data (write-through bypass, zero latency).
//   - Otherwise, mem[reg_x_addr].
//   - Both ports may read the same address. Both may hit the bypass in the same cycle.
//   - Storage has no reset other than the clear sequence.
//     Simulation X on mem before the clear completes is masked by the CLEAR read rule.
// STRUCTURE
//   - Shared package: ADDR_SIZE/WORD_SIZE defaults, REG_ZERO=0, FSM state encoding (CLEAR=0, READY=1).
//   - One natural sub-module, regfile_clear_seq: owns the FSM and clr_cnt.
//     It outputs clr_we, clr_addr and init_busy.
//   - Top level muxes the clear write against the writeback write and instantiates the storage array.
// TESTING
//   1 Reset: rst=1 for 1 cycle, then rst=0.
//     -> init_busy=1 for 31 edges, then 0. Every reg_s_data and reg_t_data read returns 0 afterwards.
//   2 Write/read: write 0xDEADBEEF to r5.
//     -> Next cycle, s_addr=5 returns 0xDEADBEEF. t_addr=6 returns 0.
//   3 r0: we=1, addr=0, data=0xFFFFFFFF.
//     -> Same cycle and next cycle, reads of r0 return 0 on both ports.
//   4 Bypass: we=1, addr=7, data=0x12345678, with s_addr=t_addr=7 in the same cycle.
//     -> Both ports return 0x12345678 before the edge.
//   5 Write during CLEAR: at clear cycle 3, write r9=0xAAAA0000.
//     -> After init_busy falls, r9 reads 0.
//   6 Reset mid-clear: rst pulsed at clear cycle 10.
//     -> init_busy stays high for 31 edges after the second rst edge.
//   6 (cont.) Preload: r3=0x55 before rst.
//     -> After the clear completes, r3 reads 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes, the zero-register index and the clear-FSM encoding
package regfile_pkg;
    localparam int DEF_ADDR_SIZE = 5;
    localparam int DEF_WORD_SIZE = 32;
    localparam int REG_ZERO      = 0;
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;
endpackage

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq: after reset, walks addresses 1..max writing zero and holds init_busy
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 clr_we,
    output logic [ADDR_SIZE-1:0] clr_addr,
    output logic                 init_busy
);
    state_t               state;
    logic [ADDR_SIZE-1:0] clr_cnt;

    // Clear sequencer: r0 is never stored, so the walk starts at 1 and ends at the top address
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            clr_cnt   <= ADDR_SIZE'(1);
            init_busy <= 1'b1;
        end else if (state == CLEAR) begin
            clr_cnt <= (clr_cnt == '1) ? clr_cnt : clr_cnt + 1'b1;
            if (clr_cnt == '1) begin
                state     <= READY;
                init_busy <= 1'b0;
            end
        end
    end

    // The clear write is live for every CLEAR cycle; it also masks reads of unclear storage
    always_comb begin
        clr_we   = (state == CLEAR);
        clr_addr = clr_cnt;
    end
endmodule

// File: rtl/regfile.sv
// regfile: MIPS 2-read/1-write register file with r0 hardwired to zero and write-through bypass
module regfile
    import regfile_pkg::*;
#(
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int WORD_SIZE = DEF_WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 reg_d_we,
    input  logic [ADDR_SIZE-1:0] reg_d_addr,
    input  logic [WORD_SIZE-1:0] reg_d_data,
    input  logic [ADDR_SIZE-1:0] reg_s_addr,
    output logic [WORD_SIZE-1:0] reg_s_data,
    input  logic [ADDR_SIZE-1:0] reg_t_addr,
    output logic [WORD_SIZE-1:0] reg_t_data,
    output logic                 init_busy
);
    localparam logic [ADDR_SIZE-1:0] ZERO_ADDR = ADDR_SIZE'(REG_ZERO);

    logic                 clr_we;
    logic [ADDR_SIZE-1:0] clr_addr;
    logic                 we;
    logic [ADDR_SIZE-1:0] waddr;
    logic [WORD_SIZE-1:0] wdata;
    logic [WORD_SIZE-1:0] mem [2**ADDR_SIZE];

    regfile_clear_seq #(.ADDR_SIZE(ADDR_SIZE)) u_clear_seq (
        .clk       (clk),
        .rst       (rst),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .init_busy (init_busy)
    );

    // Clear walk owns the write port while clearing; writeback is dropped then and on the rst cycle
    always_comb begin
        we    = clr_we | (reg_d_we & (reg_d_addr != ZERO_ADDR) & ~rst);
        waddr = clr_we ? clr_addr : reg_d_addr;
        wdata = clr_we ? '0 : reg_d_data;
    end

    // Storage array; only the clear walk initialises it
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read ports: r0 and clearing read zero, then same-cycle writeback bypass, then storage
    always_comb begin
        reg_s_data = (reg_s_addr == ZERO_ADDR || clr_we) ? '0 :
                     (reg_d_we && reg_d_addr == reg_s_addr) ? reg_d_data : mem[reg_s_addr];
        reg_t_data = (reg_t_addr == ZERO_ADDR || clr_we) ? '0 :
                     (reg_d_we && reg_d_addr == reg_t_addr) ? reg_d_data : mem[reg_t_addr];
    end
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: randomized and directed checks of regfile against an array-based reference model
module tb_regfile;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        reg_d_we = 1'b0;
    logic [4:0]  reg_d_addr = '0;
    logic [31:0] reg_d_data = '0;
    logic [4:0]  reg_s_addr = '0;
    logic [31:0] reg_s_data;
    logic [4:0]  reg_t_addr = '0;
    logic [31:0] reg_t_data;
    logic        init_busy;

    int checks = 0;
    int errors = 0;

    // Reference model: register contents plus how many more edges the clear still needs
    logic [31:0] model [32];
    int          busy_left = 31;

    regfile dut (
        .clk        (clk),
        .rst        (rst),
        .reg_d_we   (reg_d_we),
        .reg_d_addr (reg_d_addr),
        .reg_d_data (reg_d_data),
        .reg_s_addr (reg_s_addr),
        .reg_s_data (reg_s_data),
        .reg_t_addr (reg_t_addr),
        .reg_t_data (reg_t_data),
        .init_busy  (init_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0 || busy_left != 0) return 32'h0;
        if (reg_d_we && reg_d_addr == a) return reg_d_data;
        return model[a];
    endfunction

    // Advance the model by one edge using the inputs currently driven, then step the DUT
    task automatic tick();
        if (rst) begin
            busy_left = 31;
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (busy_left > 0) begin
            busy_left--;
        end else if (reg_d_we && reg_d_addr != 5'd0) begin
            model[reg_d_addr] = reg_d_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 31; i++) begin
            reg_s_addr = 5'($urandom_range(1, 31));
            reg_t_addr = 5'($urandom_range(1, 31));
            #1;
            checks++;
            if (init_busy !== 1'b1) begin
                errors++;
                $display("FAIL reset_busy edge=%0d got=%b want=1", i, init_busy);
            end
            checks++;
            if (reg_s_data !== 32'h0 || reg_t_data !== 32'h0) begin
                errors++;
                $display("FAIL reset_clear_read s=%h t=%h want=0", reg_s_data, reg_t_data);
            end
            tick();
        end
        checks++;
        if (init_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_fall got=%b want=0", init_busy);
        end
        for (int a = 0; a < 32; a++) begin
            reg_s_addr = 5'(a);
            reg_t_addr = 5'(31 - a);
            #1;
            checks++;
            if (reg_s_data !== 32'h0 || reg_t_data !== 32'h0) begin
                errors++;
                $display("FAIL reset_zero a=%0d s=%h t=%h want=0", a, reg_s_data, reg_t_data);
            end
        end
    endtask

    task automatic test_write_read();
        reg_d_we = 1'b1; reg_d_addr = 5'd5; reg_d_data = 32'hDEADBEEF;
        tick();
        reg_d_we = 1'b0;
        reg_s_addr = 5'd5; reg_t_addr = 5'd6;
        #1;
        checks++;
        if (reg_s_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_read_r5 got=%h want=deadbeef", reg_s_data);
        end
        checks++;
        if (reg_t_data !== 32'h0) begin
            errors++;
            $display("FAIL write_read_r6 got=%h want=0", reg_t_data);
        end
    endtask

    task automatic test_r0();
        reg_d_we = 1'b1; reg_d_addr = 5'd0; reg_d_data = 32'hFFFFFFFF;
        reg_s_addr = 5'd0; reg_t_addr = 5'd0;
        #1;
        checks++;
        if (reg_s_data !== 32'h0 || reg_t_data !== 32'h0) begin
            errors++;
            $display("FAIL r0_same_cycle s=%h t=%h want=0", reg_s_data, reg_t_data);
        end
        tick();
        reg_d_we = 1'b0;
        #1;
        checks++;
        if (reg_s_data !== 32'h0 || reg_t_data !== 32'h0) begin
            errors++;
            $display("FAIL r0_next_cycle s=%h t=%h want=0", reg_s_data, reg_t_data);
        end
    endtask

    task automatic test_bypass();
        reg_d_we = 1'b1; reg_d_addr = 5'd7; reg_d_data = 32'h12345678;
        reg_s_addr = 5'd7; reg_t_addr = 5'd7;
        #1;
        checks++;
        if (reg_s_data !== 32'h12345678 || reg_t_data !== 32'h12345678) begin
            errors++;
            $display("FAIL bypass s=%h t=%h want=12345678", reg_s_data, reg_t_data);
        end
        tick();
        reg_d_we = 1'b0;
        #1;
        checks++;
        if (reg_s_data !== 32'h12345678) begin
            errors++;
            $display("FAIL bypass_stored got=%h want=12345678", reg_s_data);
        end
    endtask

    task automatic test_write_during_clear();
        int n;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        reg_d_we = 1'b1; reg_d_addr = 5'd9; reg_d_data = 32'hAAAA0000;
        tick();
        reg_d_we = 1'b0;
        n = 0;
        while (init_busy !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (init_busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_write_timeout busy=%b want=0", init_busy);
        end
        reg_s_addr = 5'd9; reg_t_addr = 5'd9;
        #1;
        checks++;
        if (reg_s_data !== 32'h0 || reg_t_data !== 32'h0) begin
            errors++;
            $display("FAIL clear_write_r9 s=%h t=%h want=0", reg_s_data, reg_t_data);
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        reg_d_we = 1'b1; reg_d_addr = 5'd3; reg_d_data = 32'h55;
        tick();
        reg_d_we = 1'b0;
        reg_s_addr = 5'd3;
        #1;
        checks++;
        if (reg_s_data !== 32'h55) begin
            errors++;
            $display("FAIL preload_r3 got=%h want=55", reg_s_data);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        while (init_busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        checks++;
        if (n != 31) begin
            errors++;
            $display("FAIL mid_clear_busy_edges got=%0d want=31", n);
        end
        reg_s_addr = 5'd3; reg_t_addr = 5'd3;
        #1;
        checks++;
        if (reg_s_data !== 32'h0 || reg_t_data !== 32'h0) begin
            errors++;
            $display("FAIL mid_clear_r3 s=%h t=%h want=0", reg_s_data, reg_t_data);
        end
    endtask

    task automatic test_random();
        logic [31:0] es, et;
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 79) == 0);
            reg_d_we   = $urandom_range(0, 2) != 0;
            reg_d_addr = 5'($urandom_range(0, 31));
            reg_d_data = $urandom;
            reg_s_addr = ($urandom_range(0, 3) == 0) ? reg_d_addr : 5'($urandom_range(0, 31));
            reg_t_addr = ($urandom_range(0, 3) == 0) ? reg_d_addr : 5'($urandom_range(0, 31));
            #1;
            es = exp_read(reg_s_addr);
            et = exp_read(reg_t_addr);
            checks++;
            if (reg_s_data !== es) begin
                errors++;
                $display("FAIL rand_s i=%0d a=%0d got=%h want=%h", i, reg_s_addr, reg_s_data, es);
            end
            checks++;
            if (reg_t_data !== et) begin
                errors++;
                $display("FAIL rand_t i=%0d a=%0d got=%h want=%h", i, reg_t_addr, reg_t_data, et);
            end
            checks++;
            if (init_busy !== (busy_left != 0)) begin
                errors++;
                $display("FAIL rand_busy i=%0d got=%b want=%b", i, init_busy, busy_left != 0);
            end
            tick();
        end
        rst = 1'b0;
        reg_d_we = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        @(posedge clk);
        #1;
        test_reset();
        test_write_read();
        test_r0();
        test_bypass();
        test_write_during_clear();
        test_reset_mid_clear();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end
endmodule
